// File: rtl/digit_scan_ctrl_pkg.sv
// Shared constants for the digit scan path: scan state encoding and digit count.
// Used by the scan controller, the 2-to-4 digit decoder and the display data path.
package digit_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

endpackage

// File: rtl/digit_scan_ctrl_prescaler.sv
// Loadable up/down slot counter with a terminal-count flag.
// tc_next is the flag the counter will present after the coming edge, which lets the
// controller register its slot-end outputs one cycle ahead without re-deriving the count.
module scan_prescaler #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         up,
    input  logic [W-1:0] load_value,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         tc,
    output logic         tc_next
);

    logic [W-1:0] count_d;

    // Next count: reload takes priority, otherwise step in the requested direction.
    always_comb begin
        count_d = count;
        if (load) begin
            count_d = load_value;
        end else if (up) begin
            count_d = count + 1'b1;
        end else begin
            count_d = count - 1'b1;
        end
        tc_next = (count_d == term);
    end

    // Count register and registered terminal-count flag for the current slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            count <= count_d;
            tc    <= tc_next;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexing scan controller for the 2-to-4 digit decoder.
// Steps through enabled digit positions, one SHOW slot of DIV cycles each, with
// registered tick / frame_done pulses on the last SHOW cycle.
// Optional feature: define SCAN_BLANK_EN to insert a BLANK slot of BLANK_CYC cycles
// after every SHOW slot; without it SHOW follows SHOW directly and blank stays low
// outside IDLE.
module digit_scan_ctrl
    import digit_scan_ctrl_pkg::*;
#(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit_mask,
    output logic       s0,
    output logic       s1,
    output logic       blank,
    output logic       tick,
    output logic       frame_done
);

    localparam int MAX_CNT = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CW      = (MAX_CNT <= 1) ? 1 : $clog2(MAX_CNT);

    scan_state_t      state;
    scan_state_t      state_n;
    logic [SEL_W-1:0] index;
    logic [SEL_W-1:0] index_n;
    logic [SEL_W-1:0] adv_index;
    logic [SEL_W-1:0] first_index;
    logic             blank_d;
    logic             tick_d;
    logic             frame_done_d;

    logic             cnt_load;
    logic [CW-1:0]    cnt_term;
    logic [CW-1:0]    cnt_count;
    logic             cnt_tc;
    logic             cnt_tc_next;

    // Next enabled digit after cur in ascending order, wrapping 3->0; cur itself if it
    // is the only one enabled. Starting from 3 this yields the lowest enabled digit.
    function automatic logic [SEL_W-1:0] next_index(input logic [SEL_W-1:0] cur,
                                                    input logic [NUM_DIGITS-1:0] mask);
        logic [SEL_W-1:0] result;
        logic [SEL_W-1:0] idx;
        logic             found;
        result = cur;
        found  = 1'b0;
        for (int step = 1; step <= NUM_DIGITS; step++) begin
            idx = cur + SEL_W'(step);
            if (!found && mask[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    assign adv_index   = next_index(index, digit_mask);
    assign first_index = next_index(SEL_W'(NUM_DIGITS - 1), digit_mask);

    scan_prescaler #(
        .W(CW)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .up         (1'b1),
        .load_value ('0),
        .term       (cnt_term),
        .count      (cnt_count),
        .tc         (cnt_tc),
        .tc_next    (cnt_tc_next)
    );

    // Next state, next index, counter control and next values of the registered outputs.
    always_comb begin
        state_n  = state;
        index_n  = index;
        cnt_load = 1'b1;
        case (state)
            IDLE: begin
                if (en && (digit_mask != '0)) begin
                    state_n = SHOW;
                    index_n = first_index;
                end
            end
            SHOW: begin
                if (cnt_tc) begin
                    index_n = adv_index;
`ifdef SCAN_BLANK_EN
                    state_n = BLANK;
`else
                    state_n = SHOW;
`endif
                end else begin
                    cnt_load = 1'b0;
                end
            end
            BLANK: begin
                if (cnt_tc) begin
                    state_n = SHOW;
                end else begin
                    cnt_load = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (!en) begin
            state_n  = IDLE;
            index_n  = index;
            cnt_load = 1'b1;
        end

        cnt_term     = (state_n == BLANK) ? CW'(BLANK_CYC - 1) : CW'(DIV - 1);
        tick_d       = (state_n == SHOW) && cnt_tc_next;
        frame_done_d = tick_d && (next_index(index_n, digit_mask) <= index_n);
        blank_d      = (state_n != SHOW);
    end

    // State, select index and all outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            index      <= '0;
            blank      <= 1'b1;
            tick       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            index      <= index_n;
            blank      <= blank_d;
            tick       <= tick_d;
            frame_done <= frame_done_d;
        end
    end

    assign s0 = index[0];
    assign s1 = index[1];

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed testbench for digit_scan_ctrl with DIV=4, BLANK_CYC=2.
// Expected traces follow the slot structure: DIV cycles lit, then (if SCAN_BLANK_EN)
// BLANK_CYC dark cycles already showing the next digit.
module tb_digit_scan_ctrl;

    localparam int DIV = 4;
`ifdef SCAN_BLANK_EN
    localparam int BLK = 2;
`else
    localparam int BLK = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] digit_mask = 4'h0;
    logic       s0;
    logic       s1;
    logic       blank;
    logic       tick;
    logic       frame_done;

    int checks = 0;
    int passes = 0;

    digit_scan_ctrl #(
        .DIV       (DIV),
        .BLANK_CYC (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digit_mask (digit_mask),
        .s0         (s0),
        .s1         (s1),
        .blank      (blank),
        .tick       (tick),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Compares an observed value against its expected value and counts the result.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
        end else begin
            passes++;
        end
    endtask

    // Drives the inputs, then advances to 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [3:0] m);
        rst        = r;
        en         = e;
        digit_mask = m;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] obsAll();
        return {3'b000, blank, s1, s0, tick, frame_done};
    endfunction

    function automatic logic [7:0] expAll(input logic b, input logic [1:0] sel, input logic t, input logic f);
        return {3'b000, b, sel, t, f};
    endfunction

    // Expects `frames` complete frames over the k digits packed in seq (2 bits each, ascending).
    task automatic expectSlots(input string tag, input logic [3:0] m, input logic [7:0] seq,
                               input int k, input int frames);
        logic [1:0] d;
        logic [1:0] nd;
        logic       last;
        logic       endSlot;
        for (int f = 0; f < frames; f++) begin
            for (int j = 0; j < k; j++) begin
                d    = seq[2*j +: 2];
                nd   = seq[2*((j + 1) % k) +: 2];
                last = (j == k - 1);
                for (int c = 0; c < DIV; c++) begin
                    applyStimulus(1'b0, 1'b1, m);
                    endSlot = (c == DIV - 1);
                    checkOutput($sformatf("%s_show_f%0d_d%0d_c%0d", tag, f, d, c), obsAll(),
                                expAll(1'b0, d, endSlot, endSlot && last));
                end
                for (int c = 0; c < BLK; c++) begin
                    applyStimulus(1'b0, 1'b1, m);
                    checkOutput($sformatf("%s_blank_f%0d_d%0d_c%0d", tag, f, nd, c), obsAll(),
                                expAll(1'b1, nd, 1'b0, 1'b0));
                end
            end
        end
    endtask

    // Drops en and checks the block sits dark in IDLE.
    task automatic goIdle(input string tag);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b0, 1'b0, 4'h0);
            checkOutput(tag, {5'b0, blank, tick, frame_done}, 8'b0000_0100);
        end
    endtask

    initial begin
        $display("[TB] digit_scan_ctrl DIV=%0d blank cycles=%0d", DIV, BLK);

        applyStimulus(1'b1, 1'b0, 4'h0);
        applyStimulus(1'b1, 1'b1, 4'hF);
        checkOutput("reset", obsAll(), expAll(1'b1, 2'd0, 1'b0, 1'b0));

        expectSlots("all", 4'hF, {2'd3, 2'd2, 2'd1, 2'd0}, 4, 2);
        goIdle("idle_after_all");

        expectSlots("sparse", 4'b1010, {4'b0000, 2'd3, 2'd1}, 2, 2);
        goIdle("idle_after_sparse");

        expectSlots("single", 4'b0100, {6'b000000, 2'd2}, 1, 3);
        goIdle("idle_after_single");

        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 1'b1, 4'h0);
            checkOutput("empty_mask", {5'b0, blank, tick, frame_done}, 8'b0000_0100);
        end

        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b1, 4'hF);
            checkOutput($sformatf("drop_pre_c%0d", c), obsAll(), expAll(1'b0, 2'd0, 1'b0, 1'b0));
        end
        applyStimulus(1'b0, 1'b0, 4'hF);
        checkOutput("drop_idle", obsAll(), expAll(1'b1, 2'd0, 1'b0, 1'b0));
        applyStimulus(1'b0, 1'b0, 4'hF);
        checkOutput("drop_idle_hold", obsAll(), expAll(1'b1, 2'd0, 1'b0, 1'b0));
        expectSlots("reenable", 4'hF, {2'd3, 2'd2, 2'd1, 2'd0}, 4, 1);
        goIdle("idle_after_reenable");

        for (int c = 0; c < DIV + 1; c++) begin
            applyStimulus(1'b0, 1'b1, 4'hF);
        end
        checkOutput("pre_reset_sel", {6'b0, s1, s0}, 8'd1);
        applyStimulus(1'b1, 1'b1, 4'hF);
        checkOutput("mid_reset", obsAll(), expAll(1'b1, 2'd0, 1'b0, 1'b0));
        applyStimulus(1'b0, 1'b0, 4'hF);
        checkOutput("post_reset_idle", obsAll(), expAll(1'b1, 2'd0, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
